spi_ctrl_seq: RTL and testbench



---
 rtl/spi_ctrl_pkg.sv | 21 ++
 rtl/spi_sync.sv | 25 ++
 rtl/spi_ctrl_seq.sv | 153 +++++++++++++++
 tb/tb_spi_ctrl_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI control sequencer: FSM state encoding and
// the bit offsets of each channel's address fields inside the control word.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_NEXT  = 2'd3
    } seq_state_e;

    // Channel k owns two adjacent fields: input addr, then output addr.
    function automatic int in_lsb(input int k, input int rbaw);
        return 2 * k * rbaw;
    endfunction

    function automatic int out_lsb(input int k, input int rbaw);
        return (2 * k + 1) * rbaw;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a parametric reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("spi_sync: STAGES must be >= 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= {STAGES{RST_VAL}};
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_ctrl_seq.sv
// SPI write-commit detector driving a per-channel decoder start sequencer.
// Optional per-channel done timeout: define SPI_CTRL_SEQ_TIMEOUT_EN.
module spi_ctrl_seq
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int SPI_ADDR_WIDTH      = 8,
    parameter int REG_BANK_ADDR_WIDTH = 4,
    parameter int NUM_CH              = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int CTRL_ADDR           = 0,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  spi_cs_n,
    input  logic                                  spi_read_en_in,
    input  logic [DATA_WIDTH-1:0]                 ctrl_reg,
    input  logic [SPI_ADDR_WIDTH-1:0]             spi_addr,
    input  logic [NUM_CH-1:0]                     dec_done,
    output logic                                  spi_read_en_out,
    output logic                                  spi_write_en_out,
    output logic [REG_BANK_ADDR_WIDTH-1:0]        spi_addr_trunc,
    output logic [NUM_CH*REG_BANK_ADDR_WIDTH-1:0] dec_in_addr,
    output logic [NUM_CH*REG_BANK_ADDR_WIDTH-1:0] dec_out_addr,
    output logic [NUM_CH-1:0]                     dec_start,
    output logic                                  busy,
    output logic [NUM_CH-1:0]                     dec_err
);

    localparam int RBAW = REG_BANK_ADDR_WIDTH;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (2 * NUM_CH * RBAW > DATA_WIDTH - 1) begin : g_bad_cfg
        $error("spi_ctrl_seq: channel address fields overlap the auto_start bit");
    end

    logic            cs_s, rd_s, cs_prev, read_seen, commit;
    logic            done_ch, timeout_hit;
    seq_state_e      state, state_nxt;
    logic [CH_W-1:0] ch, ch_nxt;
    logic            pending, pending_nxt;
    logic            unused_bits;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rd (
        .clk(clk), .reset(reset), .d(spi_read_en_in), .q(rd_s)
    );

    assign spi_read_en_out = rd_s;

    // A transaction that carried a read strobe must not commit on cs_n release.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_prev          <= 1'b1;
            read_seen        <= 1'b0;
            spi_write_en_out <= 1'b0;
        end else begin
            cs_prev          <= cs_s;
            spi_write_en_out <= cs_s && !cs_prev && !read_seen;
            if (rd_s && !cs_s)      read_seen <= 1'b1;
            else if (cs_s && !rd_s) read_seen <= 1'b0;
        end
    end

    assign spi_addr_trunc = spi_addr[RBAW-1:0];
    assign commit = spi_write_en_out && (spi_addr_trunc == RBAW'(CTRL_ADDR))
                    && ctrl_reg[DATA_WIDTH-1];
    assign unused_bits = ^{spi_addr, ctrl_reg};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_fields
        localparam int IL = in_lsb(k, RBAW);
        localparam int OL = out_lsb(k, RBAW);
        assign dec_in_addr[k*RBAW +: RBAW]  = ctrl_reg[IL +: RBAW];
        assign dec_out_addr[k*RBAW +: RBAW] = ctrl_reg[OL +: RBAW];
    end

    assign done_ch = dec_done[ch];

`ifdef SPI_CTRL_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  tmo_cnt;
    logic [NUM_CH-1:0] err_q;

    assign timeout_hit = (state == S_WAIT) && !done_ch
                         && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= '0;
        end else begin
            if (state == S_START)     tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (timeout_hit) err_q[ch] <= 1'b1;
        end
    end

    assign dec_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign dec_err     = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ch      <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        pending_nxt = pending | (commit && (state != S_IDLE));
        case (state)
            S_IDLE: if (commit) begin
                state_nxt = S_START;
                ch_nxt    = '0;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (done_ch || timeout_hit) state_nxt = S_NEXT;
            S_NEXT: begin
                if (ch != CH_W'(NUM_CH - 1)) begin
                    ch_nxt    = ch + CH_W'(1);
                    state_nxt = S_START;
                end else if (pending || commit) begin
                    // A commit landing on the final NEXT cycle restarts directly.
                    ch_nxt      = '0;
                    state_nxt   = S_START;
                    pending_nxt = pending && commit;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dec_start = '0;
        if (state == S_START) dec_start[ch] = 1'b1;
        busy = (state != S_IDLE);
    end

endmodule

// File: tb/tb_spi_ctrl_seq.sv
// Self-checking bench for spi_ctrl_seq: vector table, random transactions
// against a transaction-level model, and directed multi-cycle corner cases.
module tb_spi_ctrl_seq;

    localparam int DW   = 32;
    localparam int SAW  = 8;
    localparam int RBAW = 4;
    localparam int NCH  = 2;
    localparam int SS   = 2;
    localparam int TMO  = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_read_en_in = 1'b0;
    logic [DW-1:0] ctrl_reg = '0;
    logic [SAW-1:0] spi_addr = '0;
    logic [NCH-1:0] dec_done = '0;
    logic spi_read_en_out, spi_write_en_out, busy;
    logic [RBAW-1:0] spi_addr_trunc;
    logic [NCH*RBAW-1:0] dec_in_addr, dec_out_addr;
    logic [NCH-1:0] dec_start, dec_err;

    int checks = 0;
    int errors = 0;

    spi_ctrl_seq #(
        .DATA_WIDTH(DW), .SPI_ADDR_WIDTH(SAW), .REG_BANK_ADDR_WIDTH(RBAW),
        .NUM_CH(NCH), .SYNC_STAGES(SS), .CTRL_ADDR(0), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_read_en_in(spi_read_en_in),
        .ctrl_reg(ctrl_reg), .spi_addr(spi_addr), .dec_done(dec_done),
        .spi_read_en_out(spi_read_en_out), .spi_write_en_out(spi_write_en_out),
        .spi_addr_trunc(spi_addr_trunc), .dec_in_addr(dec_in_addr),
        .dec_out_addr(dec_out_addr), .dec_start(dec_start), .busy(busy), .dec_err(dec_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] ctrl;
        int          exp_pulses;
        bit          exp_commit;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Channel k's field pair taken straight from the control word layout.
    function automatic logic [NCH*RBAW-1:0] model_field(input logic [31:0] c, input int odd);
        logic [31:0] acc = '0;
        for (int k = 0; k < NCH; k++)
            acc = acc | (((c >> ((2 * k + odd) * RBAW)) & 32'hF) << (k * RBAW));
        return acc[NCH*RBAW-1:0];
    endfunction

    function automatic bit model_commit(input bit rd, input logic [7:0] addr, input logic [31:0] c);
        return !rd && ((addr % 16) == 0) && (c >> 31) == 1;
    endfunction

    task automatic spi_txn(input bit rd, input logic [7:0] addr, input logic [31:0] ctrl,
                           output int np, output int lat);
        np = 0;
        lat = 0;
        spi_addr = addr;
        ctrl_reg = ctrl;
        spi_cs_n = 1'b0;
        repeat (4) tick();
        if (rd) begin
            spi_read_en_in = 1'b1;
            tick();
            chk("rd_sync_lag", spi_read_en_out, 0);
            tick();
            chk("rd_sync", spi_read_en_out, 1);
            tick();
            spi_read_en_in = 1'b0;
            repeat (4) tick();
        end
        spi_cs_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (spi_write_en_out) begin
                np++;
                lat = k;
                break;
            end
        end
        if (np != 0) begin
            tick();
            if (spi_write_en_out) np++;
        end
    endtask

    task automatic run_seq(input int nseq, input int extra, input bit exact_first);
        int w, np, lat, bad;
        for (int s = 0; s < nseq; s++) begin
            for (int c = 0; c < NCH; c++) begin
                w = 0;
                while (dec_start == '0 && w < 20) begin
                    tick();
                    w++;
                end
                chk("dec_start", dec_start, 64'(1) << c);
                if (s != 0 || c != 0) chk("start_gap", w, 1);
                else if (exact_first) chk("start_gap", w, 0);
                dec_done = '1;                     // same-cycle done must be ignored
                tick();
                dec_done = '0;
                chk("start_len", dec_start, 0);
                dec_done = ~(NCH'(1) << c);        // other channel's done must be ignored
                tick();
                dec_done = '0;
                if (s == 0 && c == 0)
                    for (int e = 0; e < extra; e++) begin
                        spi_txn(1'b0, 8'h00, 32'h8000_0021, np, lat);
                        chk("busy_wr_pulse", np, 1);
                    end
                repeat ($urandom_range(0, 3)) tick();
                chk("waiting", {busy, dec_start}, {1'b1, NCH'(0)});
                dec_done = NCH'(1) << c;
                tick();
                dec_done = '0;
                chk("busy_next", busy, 1);
            end
        end
        tick();
        chk("busy_fall", busy, 0);
        bad = 0;
        repeat (10) begin
            tick();
            if (dec_start != '0) bad++;
        end
        chk("no_extra_start", bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int np, lat, bad;
        spi_txn(v.rd, v.addr, v.ctrl, np, lat);
        chk("wr_pulses", np, v.exp_pulses);
        if (v.exp_pulses > 0) chk("wr_latency", lat, SS + 1);
        chk("addr_trunc", spi_addr_trunc, v.addr % 16);
        chk("in_addr", dec_in_addr, model_field(v.ctrl, 0));
        chk("out_addr", dec_out_addr, model_field(v.ctrl, 1));
        if (v.exp_commit) run_seq(1, 0, 1'b1);
        else begin
            bad = 0;
            repeat (6) begin
                if (dec_start != '0 || busy) bad++;
                tick();
            end
            chk("no_start", bad, 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int np, lat, bad;

        vecs[0] = '{1'b1, 8'h00, 32'h8000_0021, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 32'h8000_0021, 1, 1'b1};
        vecs[2] = '{1'b0, 8'h05, 32'h8000_0021, 1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 32'h0000_0021, 1, 1'b0};
        vecs[4] = '{1'b0, 8'hF0, 32'h8765_4321, 1, 1'b1};
        vecs[5] = '{1'b1, 8'h30, 32'hFFFF_FFFF, 0, 1'b0};

        reset = 1'b1;
        repeat (3) tick();
        chk("reset_outs", {spi_write_en_out, spi_read_en_out, busy, dec_start, dec_err}, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv.rd   = ($urandom_range(0, 3) == 0);
            rv.addr = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rv.addr = rv.addr & 8'hF0;
            rv.ctrl = $urandom;
            rv.exp_pulses = rv.rd ? 0 : 1;
            rv.exp_commit = model_commit(rv.rd, rv.addr, rv.ctrl);
            run_vec(rv);
        end

        // Two commits while busy queue exactly one extra sequence.
        spi_txn(1'b0, 8'h00, 32'h8000_0021, np, lat);
        chk("pend_wr_pulse", np, 1);
        run_seq(2, 2, 1'b1);

        // Channel 0 never answers.
        spi_txn(1'b0, 8'h00, 32'h8000_0021, np, lat);
        chk("tmo_wr_pulse", np, 1);
        chk("tmo_start0", dec_start, 1);
`ifdef SPI_CTRL_SEQ_TIMEOUT_EN
        repeat (TMO) tick();
        chk("tmo_early", dec_err, 0);
        tick();
        chk("tmo_err", dec_err, 1);
        tick();
        chk("tmo_next_start", dec_start, 2);
`else
        repeat (1100) tick();
        chk("no_tmo_err", dec_err, 0);
        chk("still_wait", {busy, dec_start}, {1'b1, NCH'(0)});
        dec_done = 2'b01;
        tick();
        dec_done = '0;
        tick();
        chk("late_next_start", dec_start, 2);
`endif
        tick();
        dec_done = 2'b10;
        tick();
        dec_done = '0;
        tick();
        chk("tmo_busy_fall", busy, 0);
`ifdef SPI_CTRL_SEQ_TIMEOUT_EN
        chk("tmo_err_sticky", dec_err, 1);
`endif

        // Reset in WAIT aborts the sequence.
        spi_txn(1'b0, 8'h00, 32'h8000_0021, np, lat);
        chk("rst_wr_pulse", np, 1);
        chk("rst_start0", dec_start, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_outs", {spi_write_en_out, spi_read_en_out, busy, dec_start, dec_err}, 0);
        reset = 1'b0;
        bad = 0;
        repeat (30) begin
            tick();
            if (dec_start != '0 || busy) bad++;
        end
        chk("rst_no_start", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
